// File: rtl/mux4_rr_arbiter_if.sv
// Requester/output channel bundle for mux4_rr_arbiter.
// The lock signal exists only when MUX4_ARB_LOCK_EN is defined.
interface mux4_rr_arbiter_if #(
   parameter int DATA_W = 4
);
   logic [3:0]        req;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic [DATA_W-1:0] d;
   logic              out_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        sel;
   logic [3:0]        gnt;
   logic [3:0]        ack;
`ifdef MUX4_ARB_LOCK_EN
   logic              lock;

   modport master (
      output req, a, b, c, d, out_ready, lock,
      input  out_valid, out_data, sel, gnt, ack
   );
   modport slave (
      input  req, a, b, c, d, out_ready, lock,
      output out_valid, out_data, sel, gnt, ack
   );
`else
   modport master (
      output req, a, b, c, d, out_ready,
      input  out_valid, out_data, sel, gnt, ack
   );
   modport slave (
      input  req, a, b, c, d, out_ready,
      output out_valid, out_data, sel, gnt, ack
   );
`endif
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux output channel.
// Optional feature macro: MUX4_ARB_LOCK_EN (adds lock = re-grant same requester).
module mux4_rr_arbiter #(
   parameter int DATA_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mux4_rr_arbiter_if.slave   arb_bus
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_ptr, w_ptr_nxt;
   logic [1:0]        r_sel, w_sel_nxt;
   logic [3:0]        r_gnt, w_gnt_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_valid, w_valid_nxt;

   logic              w_accept;
   logic              w_lock;
   logic [3:0]        w_cand;
   logic [1:0]        w_start;
   logic [2:0]        w_pick;
   logic              w_found;
   logic [1:0]        w_win;
   logic [DATA_W-1:0] w_win_data;

   // Returns {found, index}; scanning from the far end lets the nearest hit win.
   function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (cand[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   assign w_accept = r_valid & arb_bus.out_ready;

`ifdef MUX4_ARB_LOCK_EN
   assign w_lock = arb_bus.lock;
`else
   assign w_lock = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_cand  = arb_bus.req;
      w_start = r_ptr;
      if (r_state == S_GRANT) begin
         if (w_lock) begin
            w_cand  = arb_bus.req;
            w_start = r_sel;
         end else begin
            // Mask the word being acked so a slow req deassert cannot re-win it.
            w_cand  = arb_bus.req & ~r_gnt;
            w_start = r_sel + 2'd1;
         end
      end
   end

   assign w_pick  = rr_pick(w_cand, w_start);
   assign w_found = w_pick[2];
   assign w_win   = w_pick[1:0];

   always_comb begin
      case (w_win)
         2'd0:    w_win_data = arb_bus.a;
         2'd1:    w_win_data = arb_bus.b;
         2'd2:    w_win_data = arb_bus.c;
         default: w_win_data = arb_bus.d;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_gnt_nxt   = r_gnt;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_GRANT;
               w_gnt_nxt   = 4'b0001 << w_win;
               w_sel_nxt   = w_win;
               w_data_nxt  = w_win_data;
               w_valid_nxt = 1'b1;
            end
         end
         S_GRANT: begin
            if (w_accept) begin
               if (!w_lock) w_ptr_nxt = r_sel + 2'd1;
               if (w_found) begin
                  w_gnt_nxt   = 4'b0001 << w_win;
                  w_sel_nxt   = w_win;
                  w_data_nxt  = w_win_data;
               end else begin
                  // sel and out_data keep the last word after going idle.
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = 4'b0000;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= 2'd0;
         r_sel   <= 2'd0;
         r_gnt   <= 4'b0000;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_gnt   <= w_gnt_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign arb_bus.out_valid = r_valid;
   assign arb_bus.out_data  = r_data;
   assign arb_bus.sel       = r_sel;
   assign arb_bus.gnt       = r_gnt;
   assign arb_bus.ack       = r_gnt & {4{w_accept}};

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: expected words are queued when stimulus
// is driven and compared when the arbiter presents an accepted word.
`timescale 1ns/1ps
module tb_mux4_rr_arbiter;
   localparam int DATA_W = 4;

   typedef struct {
      logic [1:0]        idx;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mux4_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

   mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_bus(bus)
   );

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.req       = 4'b0000;
      bus.a         = '0;
      bus.b         = '0;
      bus.c         = '0;
      bus.d         = '0;
      bus.out_ready = 1'b0;
`ifdef MUX4_ARB_LOCK_EN
      bus.lock      = 1'b0;
`endif
   endtask

   task automatic apply_reset;
      rst_n = 1'b0;
      clear_inputs();
      sb.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      clear_inputs();
      #1 rst_n = 1'b0;
      #3;
      checks++;
      if ({bus.out_valid, bus.gnt, bus.ack, bus.out_data, bus.sel} !== '0) begin
         errors++;
         $display("FAIL reset_initial: got valid=%b gnt=%b ack=%b data=%h sel=%0d want all 0",
                  bus.out_valid, bus.gnt, bus.ack, bus.out_data, bus.sel);
      end
      apply_reset();
      bus.req = 4'b0100; bus.c = 4'hA; bus.out_ready = 1'b0;
      next_cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hA || bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL reset_pregrant: got valid=%b data=%h gnt=%b want 1 a 0100",
                  bus.out_valid, bus.out_data, bus.gnt);
      end
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.gnt, bus.ack, bus.out_data, bus.sel} !== '0) begin
         errors++;
         $display("FAIL reset_async: got valid=%b gnt=%b ack=%b data=%h sel=%0d want all 0",
                  bus.out_valid, bus.gnt, bus.ack, bus.out_data, bus.sel);
      end
      bus.req = 4'b1111; bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
      bus.out_ready = 1'b0;
      next_cycle();
      #2 rst_n = 1'b1;
      next_cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.gnt !== 4'b0001 || bus.sel !== 2'd0 || bus.out_data !== 4'h1) begin
         errors++;
         $display("FAIL reset_first_grant: got valid=%b gnt=%b sel=%0d data=%h want 1 0001 0 1",
                  bus.out_valid, bus.gnt, bus.sel, bus.out_data);
      end
   endtask

   task automatic test_single;
      apply_reset();
      sb.push_back('{2'd2, 4'hA});
      bus.req = 4'b0100; bus.c = 4'hA; bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency: got valid=%b want 0", bus.out_valid);
      end
      next_cycle();
      begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if ({bus.out_valid, bus.gnt, bus.sel, bus.out_data, bus.ack} !==
             {1'b1, 4'(4'b0001 << e.idx), e.idx, e.data, 4'(4'b0001 << e.idx)}) begin
            errors++;
            $display("FAIL single_word: got valid=%b gnt=%b sel=%0d data=%h ack=%b want sel=%0d data=%h",
                     bus.out_valid, bus.gnt, bus.sel, bus.out_data, bus.ack, e.idx, e.data);
         end
      end
      next_cycle();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0000 || bus.ack !== 4'b0000 ||
          bus.sel !== 2'd2 || bus.out_data !== 4'hA) begin
         errors++;
         $display("FAIL single_idle: got valid=%b gnt=%b ack=%b sel=%0d data=%h want 0 0000 0000 2 a",
                  bus.out_valid, bus.gnt, bus.ack, bus.sel, bus.out_data);
      end
   endtask

   task automatic test_round_robin;
      int cyc;
      apply_reset();
      sb.push_back('{2'd0, 4'h1});
      sb.push_back('{2'd1, 4'h2});
      sb.push_back('{2'd2, 4'h3});
      sb.push_back('{2'd3, 4'h4});
      sb.push_back('{2'd0, 4'h1});
      bus.req = 4'b1111; bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
      bus.out_ready = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         next_cycle();
         cyc++;
         if (bus.out_valid === 1'b1) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.out_data !== e.data || bus.sel !== e.idx ||
                bus.gnt !== 4'(4'b0001 << e.idx) || bus.ack !== 4'(4'b0001 << e.idx)) begin
               errors++;
               $display("FAIL rr_word: got data=%h sel=%0d gnt=%b ack=%b want data=%h sel=%0d",
                        bus.out_data, bus.sel, bus.gnt, bus.ack, e.data, e.idx);
            end
         end
      end
      checks++;
      if (sb.size() != 0 || cyc != 5) begin
         errors++;
         $display("FAIL rr_throughput: got cycles=%0d pending=%0d want cycles=5 pending=0",
                  cyc, sb.size());
      end
   endtask

   task automatic test_backpressure;
      apply_reset();
      sb.push_back('{2'd1, 4'h5});
      bus.req = 4'b0010; bus.b = 4'h5; bus.out_ready = 1'b0;
      next_cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.gnt !== 4'b0010 || bus.out_data !== 4'h5) begin
         errors++;
         $display("FAIL bp_grant: got valid=%b gnt=%b data=%h want 1 0010 5",
                  bus.out_valid, bus.gnt, bus.out_data);
      end
      for (int i = 0; i < 3; i++) begin
         bus.b   = 4'hF;
         bus.req = (i == 1) ? 4'b0000 : 4'b0010;
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h5 || bus.gnt !== 4'b0010 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%h gnt=%b ack=%b want 1 5 0010 0000",
                     i, bus.out_valid, bus.out_data, bus.gnt, bus.ack);
         end
         next_cycle();
      end
      bus.out_ready = 1'b1;
      #1;
      begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (bus.ack !== 4'(4'b0001 << e.idx) || bus.out_data !== e.data || bus.sel !== e.idx) begin
            errors++;
            $display("FAIL bp_accept: got ack=%b data=%h sel=%0d want sel=%0d data=%h",
                     bus.ack, bus.out_data, bus.sel, e.idx, e.data);
         end
      end
      next_cycle();
      checks++;
      if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_single_ack: got ack=%b valid=%b want 0000 0", bus.ack, bus.out_valid);
      end
   endtask

   task automatic test_lone_requester;
      logic exp_v;
      apply_reset();
      bus.req = 4'b0001; bus.a = 4'h7; bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         exp_v = (i % 2 == 0);
         checks++;
         if (bus.out_valid !== exp_v || bus.ack !== (exp_v ? 4'b0001 : 4'b0000) ||
             (exp_v && bus.out_data !== 4'h7)) begin
            errors++;
            $display("FAIL lone_cycle[%0d]: got valid=%b ack=%b data=%h want valid=%b",
                     i, bus.out_valid, bus.ack, bus.out_data, exp_v);
         end
      end
   endtask

`ifdef MUX4_ARB_LOCK_EN
   task automatic test_lock;
      apply_reset();
      bus.req = 4'b1111; bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
      bus.out_ready = 1'b0; bus.lock = 1'b1;
      next_cycle();
      checks++;
      if (bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL lock_idle_ignored: got gnt=%b want 0001", bus.gnt);
      end
      bus.lock = 1'b0; bus.out_ready = 1'b1;
      next_cycle();
      bus.lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.gnt !== 4'b0010 || bus.out_data !== 4'h2) begin
            errors++;
            $display("FAIL lock_regrant[%0d]: got gnt=%b data=%h want 0010 2", i, bus.gnt, bus.out_data);
         end
         if (i < 2) next_cycle();
      end
      bus.lock = 1'b0;
      next_cycle();
      checks++;
      if (bus.gnt !== 4'b0100 || bus.out_data !== 4'h3) begin
         errors++;
         $display("FAIL lock_release: got gnt=%b data=%h want 0100 3", bus.gnt, bus.out_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_lone_requester();
`ifdef MUX4_ARB_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
